// File: rtl/zap_wb_arbiter2.sv
// Two-master Wishbone B3 arbiter: merges the code-side and data-side next-cycle
// requests onto one registered bus port, with burst hold, round-robin and a stall watchdog.
module zap_wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_c_wb_cyc_nxt,
    input  logic        i_c_wb_stb_nxt,
    input  logic        i_c_wb_wen_nxt,
    input  logic [31:0] i_c_wb_adr_nxt,
    input  logic [31:0] i_c_wb_dat_nxt,
    input  logic [3:0]  i_c_wb_sel_nxt,
    input  logic [2:0]  i_c_wb_cti_nxt,
    output logic        o_c_wb_ack,
    output logic        o_c_wb_err,

    input  logic        i_d_wb_cyc_nxt,
    input  logic        i_d_wb_stb_nxt,
    input  logic        i_d_wb_wen_nxt,
    input  logic [31:0] i_d_wb_adr_nxt,
    input  logic [31:0] i_d_wb_dat_nxt,
    input  logic [3:0]  i_d_wb_sel_nxt,
    input  logic [2:0]  i_d_wb_cti_nxt,
    output logic        o_d_wb_ack,
    output logic        o_d_wb_err,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    output logic [31:0] o_wb_dat_rd
);

    typedef enum logic {
        OWNER_CODE = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam bit          WDOG_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WDOG_LAST = 16'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

    owner_t      owner_q, owner_d;
    logic [15:0] wdogCnt_q, wdogCnt_d;

    logic        wbCyc_d, wbStb_d, wbWen_d;
    logic [31:0] wbAdr_d, wbDat_d;
    logic [3:0]  wbSel_d;
    logic [2:0]  wbCti_d;

    logic        ownerCycNxt;
    logic        atBoundary;
    logic        wdogFire;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            owner_q   <= OWNER_CODE;
            wdogCnt_q <= 16'd0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_wen  <= 1'b0;
            o_wb_adr  <= 32'd0;
            o_wb_dat  <= 32'd0;
            o_wb_sel  <= 4'd0;
            o_wb_cti  <= 3'b000;
        end else begin
            owner_q   <= owner_d;
            wdogCnt_q <= wdogCnt_d;
            o_wb_cyc  <= wbCyc_d;
            o_wb_stb  <= wbStb_d;
            o_wb_wen  <= wbWen_d;
            o_wb_adr  <= wbAdr_d;
            o_wb_dat  <= wbDat_d;
            o_wb_sel  <= wbSel_d;
            o_wb_cti  <= wbCti_d;
        end
    end

    // Ownership may only move once the owner has let go of cyc_nxt, which keeps bursts intact.
    always_comb begin
        ownerCycNxt = (owner_q == OWNER_CODE) ? i_c_wb_cyc_nxt : i_d_wb_cyc_nxt;
        atBoundary  = (!o_wb_stb || i_wb_ack) && !ownerCycNxt;
        wdogFire    = WDOG_EN && o_wb_stb && !i_wb_ack && (wdogCnt_q == WDOG_LAST);

        owner_d = owner_q;
        if (atBoundary) begin
            case ({i_c_wb_cyc_nxt, i_d_wb_cyc_nxt})
                2'b11:   owner_d = (owner_q == OWNER_CODE) ? OWNER_DATA : OWNER_CODE;
                2'b10:   owner_d = OWNER_CODE;
                2'b01:   owner_d = OWNER_DATA;
                default: owner_d = owner_q;
            endcase
        end

        if (owner_d == OWNER_CODE) begin
            wbCyc_d = i_c_wb_cyc_nxt;
            wbStb_d = i_c_wb_stb_nxt;
            wbWen_d = i_c_wb_wen_nxt;
            wbAdr_d = i_c_wb_adr_nxt;
            wbDat_d = i_c_wb_dat_nxt;
            wbSel_d = i_c_wb_sel_nxt;
            wbCti_d = i_c_wb_cti_nxt;
        end else begin
            wbCyc_d = i_d_wb_cyc_nxt;
            wbStb_d = i_d_wb_stb_nxt;
            wbWen_d = i_d_wb_wen_nxt;
            wbAdr_d = i_d_wb_adr_nxt;
            wbDat_d = i_d_wb_dat_nxt;
            wbSel_d = i_d_wb_sel_nxt;
            wbCti_d = i_d_wb_cti_nxt;
        end

        // A timed-out cycle is torn down even if the master still asks for it.
        if (wdogFire) begin
            wbCyc_d = 1'b0;
            wbStb_d = 1'b0;
        end

        if (!WDOG_EN || !o_wb_stb || i_wb_ack || wdogFire) begin
            wdogCnt_d = 16'd0;
        end else begin
            wdogCnt_d = wdogCnt_q + 16'd1;
        end
    end

    always_comb begin
        o_c_wb_ack  = (owner_q == OWNER_CODE) && ((i_wb_ack && o_wb_stb) || wdogFire);
        o_d_wb_ack  = (owner_q == OWNER_DATA) && ((i_wb_ack && o_wb_stb) || wdogFire);
        o_c_wb_err  = (owner_q == OWNER_CODE) && wdogFire;
        o_d_wb_err  = (owner_q == OWNER_DATA) && wdogFire;
        o_wb_dat_rd = i_wb_dat;
    end

endmodule

// File: doc/zap_wb_arbiter2.md
Name: zap_wb_arbiter2

Overview:
- Two-master Wishbone B3 arbiter directly downstream of the instruction-side and data-side cache/MMU tops.
- Consumes each side's combinational *_nxt bus requests and drives one registered Wishbone master port to the external bus.
- Routes ACK and read data back to the owning side.
- Holds ownership across multi-beat bursts, alternates ownership round-robin, and terminates hung cycles via a watchdog.

Parameters:
TIMEOUT, 1024, cycles stb may stay high without ack before forced termination; 0 disables watchdog; legal range 0..65535.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_c_wb_cyc_nxt, i_c_wb_stb_nxt, i_c_wb_wen_nxt  in  1 each  code-side next-cycle cyc/stb/wen
i_c_wb_adr_nxt, i_c_wb_dat_nxt  in  32 each  code-side next address / write data
i_c_wb_sel_nxt  in  4  code-side byte select
i_c_wb_cti_nxt  in  3  code-side cycle type
o_c_wb_ack, o_c_wb_err  out  1 each  ack / watchdog error to code side
i_d_wb_cyc_nxt, i_d_wb_stb_nxt, i_d_wb_wen_nxt, i_d_wb_adr_nxt, i_d_wb_dat_nxt, i_d_wb_sel_nxt, i_d_wb_cti_nxt  in  (same widths)  data-side equivalents
o_d_wb_ack, o_d_wb_err  out  1 each  ack / watchdog error to data side
o_wb_cyc, o_wb_stb, o_wb_wen  out  1 each  registered bus controls
o_wb_adr, o_wb_dat  out  32 each  registered address / write data
o_wb_sel  out  4  registered byte select
o_wb_cti  out  3  registered cycle type
i_wb_dat  in  32  bus read data
i_wb_ack  in  1  bus acknowledge
o_wb_dat_rd  out  32  i_wb_dat passed combinationally to both sides

Behaviour:
- Reset: i_reset synchronous, active-high, clock i_clk.
  - Reset values: all o_wb_* = 0, o_wb_cti = 3'b000 (CTI_CLASSIC), owner_ff = CODE, wdog_cnt = 0, o_c/d_wb_ack = 0, o_c/d_wb_err = 0.
  - Reset mid-cycle drops cyc/stb on the next edge with no ack or err emitted.
- State: owner_ff in {CODE, DATA}; bus is idle whenever o_wb_cyc = 0.
- Boundary condition: boundary = (!o_wb_stb || i_wb_ack) && !owner_cyc_nxt.
  - owner_cyc_nxt is the current owner's cyc_nxt.
  - Ownership never changes while the owner holds cyc_nxt high, so bursts (cti 3'b010 through 3'b111) are never interleaved.
- Arbitration at a boundary, producing owner_nxt:
  - Both sides request (cyc_nxt=1): grant the side != owner_ff (round-robin).
  - Exactly one side requests: grant it.
  - Neither requests: keep owner_ff.
  - Outside a boundary, owner_nxt = owner_ff.
- Output path: every cycle, o_wb_* <= selected side's *_nxt, where selected = owner_nxt. Latency is one cycle from *_nxt to bus.
- Ack routing (combinational):
  - o_c_wb_ack = i_wb_ack && o_wb_stb && owner_ff==CODE.
  - o_d_wb_ack likewise for DATA.
  - The non-owner always sees ack=0.
  - An ack arriving while o_wb_stb=0 is ignored.
- Watchdog (TIMEOUT>0):
  - 16-bit wdog_cnt increments each cycle o_wb_stb && !i_wb_ack; it clears on ack or !o_wb_stb.
  - When wdog_cnt == TIMEOUT-1 and still no ack:
    - Assert owner's ack and err for exactly that cycle.
    - Register o_wb_cyc=0, o_wb_stb=0 for the next cycle, overriding *_nxt.
    - Clear wdog_cnt.
  - Read data returned with err is undefined.
  - If i_wb_ack arrives in the same cycle as the timeout, the normal ack wins and no err is issued.
- Simultaneous owner release and other-side request: the other side's *_nxt appears on the bus in the next cycle, with no idle gap.
- No combinational path from i_wb_ack to o_wb_*. The only comb paths are i_wb_ack to o_*_wb_ack/err and i_wb_dat to o_wb_dat_rd.

Test Plan:
1. Reset then idle: both cyc_nxt=0 for 10 cycles -> o_wb_cyc=0, cti=3'b000, no acks.
2. Single code read: c adr_nxt=0x0000_1000, cyc/stb_nxt=1; bus acks 3 cycles later.
   - o_wb_adr=0x1000 one cycle after request.
   - o_c_wb_ack=1 exactly once, o_d_wb_ack=0.
   - o_wb_dat_rd=i_wb_dat=0xDEADBEEF on the ack cycle.
3. Burst hold: data 4-beat burst (cti 010,010,010,111) at 0x2000 while code requests continuously.
   - All 4 beats go to DATA back-to-back.
   - CODE is granted on the cycle after the last ack.
4. Round-robin: both sides issue single writes repeatedly, each master holding its request until acked -> grants alternate C,D,C,D on successive transfers.
5. Watchdog: TIMEOUT=8, data stb with no ack.
   - o_d_wb_ack and o_d_wb_err pulse together on the 8th stalled cycle.
   - o_wb_cyc=0 on the following cycle.
   - Repeat with ack on that same cycle -> ack only, err=0.
6. Reset mid-burst: assert i_reset on beat 2 -> next cycle all o_wb_*=0, owner=CODE, no err pulse.
